// File: rtl/arm_mc_ctrl.sv
// Multicycle ARM control sequencer: fetch/decode/execute FSM, instruction decoder
// and NZCV condition unit sharing one ALU and one memory port.
module arm_mc_ctrl #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] ALUFlags,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic [3:0] Flags,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExecR  = 4'd6,
        StExecI  = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] flags_q, flags_d;

    logic [3:0] cmd;
    logic       i_bit, s_bit;
    logic [1:0] dp_alu;
    logic       dp_write, dp_known, dp_cmp;
    logic       cond_ex;
    logic       pc_write, ir_write, reg_write, mem_write;

    assign cmd   = Funct[4:1];
    assign i_bit = Funct[5];
    assign s_bit = Funct[0];

    always_comb begin
        dp_alu   = 2'b00;
        dp_write = 1'b0;
        dp_known = 1'b0;
        dp_cmp   = 1'b0;
        case (cmd)
            4'b0100: begin dp_alu = 2'b00; dp_write = 1'b1; dp_known = 1'b1; end
            4'b0010: begin dp_alu = 2'b01; dp_write = 1'b1; dp_known = 1'b1; end
            4'b0000: begin dp_alu = 2'b10; dp_write = 1'b1; dp_known = 1'b1; end
            4'b1100: begin dp_alu = 2'b11; dp_write = 1'b1; dp_known = 1'b1; end
            4'b1010: begin dp_alu = 2'b01; dp_known = 1'b1; dp_cmp = 1'b1; end
            default: ;
        endcase
    end

    // Flags are NZCV in bits [3:0].
    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = flags_q[2];
            4'b0001: cond_ex = ~flags_q[2];
            4'b0010: cond_ex = flags_q[1];
            4'b0011: cond_ex = ~flags_q[1];
            4'b0100: cond_ex = flags_q[3];
            4'b0101: cond_ex = ~flags_q[3];
            4'b0110: cond_ex = flags_q[0];
            4'b0111: cond_ex = ~flags_q[0];
            4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
            4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
            4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        ImmSrc = 3'b000;
        case (Op)
            2'b00:   ImmSrc = 3'b011;
            2'b01:   ImmSrc = 3'b001;
            2'b10:   ImmSrc = 3'b010;
            default: ImmSrc = 3'b000;
        endcase
    end

    // CondEx in ALUWB sees the old flags; the new value lands on this edge.
    always_comb begin
        flags_d = flags_q;
        if (state_q == StAluWb && cond_ex && dp_known && (s_bit || dp_cmp)) begin
            flags_d = ALUFlags;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        case (state_q)
            StFetch: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_write  = MemReady;
                pc_write  = MemReady;
                state_d   = MemReady ? StDecode : StFetch;
            end
            StDecode: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b01:   state_d = StMemAdr;
                    2'b00:   state_d = i_bit ? StExecI : StExecR;
                    2'b10:   state_d = StBranch;
                    default: state_d = StFetch;
                endcase
            end
            StMemAdr: begin
                ALUSrcB = 2'b01;
                state_d = s_bit ? StMemRd : StMemWr;
            end
            StMemRd: begin
                AdrSrc  = 1'b1;
                state_d = MemReady ? StMemWb : StMemRd;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                reg_write = cond_ex;
                state_d   = StFetch;
            end
            StMemWr: begin
                AdrSrc    = 1'b1;
                mem_write = cond_ex;
                state_d   = MemReady ? StFetch : StMemWr;
            end
            StExecR: begin
                ALUControl = dp_alu;
                state_d    = StAluWb;
            end
            StExecI: begin
                ALUSrcB    = 2'b01;
                ALUControl = dp_alu;
                state_d    = StAluWb;
            end
            StAluWb: begin
                ALUControl = dp_alu;
                reg_write  = cond_ex & dp_write;
                state_d    = StFetch;
            end
            StBranch: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pc_write  = cond_ex;
                state_d   = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            flags_q <= RESET_FLAGS;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    // Enables are gated by reset so FETCH's MemReady path cannot fire during reset.
    assign PCWrite  = pc_write & rst_n;
    assign IRWrite  = ir_write & rst_n;
    assign RegWrite = reg_write & rst_n;
    assign MemWrite = mem_write & rst_n;
    assign Flags    = flags_q;
    assign State    = state_q;

endmodule

// File: tb/tb_arm_mc_ctrl.sv
// Table-driven, scoreboarded bench for arm_mc_ctrl: per-cycle vectors of
// instruction fields and expected control outputs, plus an async-reset sequence.
module tb_arm_mc_ctrl;

    localparam logic [3:0] S_F   = 4'd0;
    localparam logic [3:0] S_D   = 4'd1;
    localparam logic [3:0] S_MA  = 4'd2;
    localparam logic [3:0] S_MRD = 4'd3;
    localparam logic [3:0] S_MWB = 4'd4;
    localparam logic [3:0] S_MWR = 4'd5;
    localparam logic [3:0] S_ER  = 4'd6;
    localparam logic [3:0] S_EI  = 4'd7;
    localparam logic [3:0] S_WB  = 4'd8;
    localparam logic [3:0] S_BR  = 4'd9;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] ALUFlags;
    logic       MemReady;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl;
    logic [2:0] ImmSrc;
    logic [3:0] Flags, State;

    always #5 clk = ~clk;

    arm_mc_ctrl #(.RESET_FLAGS(4'b0000)) dut (
        .clk(clk), .rst_n(rst_n), .Cond(Cond), .Op(Op), .Funct(Funct),
        .ALUFlags(ALUFlags), .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
        .ImmSrc(ImmSrc), .Flags(Flags), .State(State)
    );

    // Packed view: state, {pcw,irw,rw,mw}, aluc, imm, flags, {adr,srca,srcb,res}.
    logic [22:0] act_w;
    assign act_w = {State, PCWrite, IRWrite, RegWrite, MemWrite, ALUControl, ImmSrc, Flags,
                    AdrSrc, ALUSrcA, ALUSrcB, ResultSrc};

    typedef struct {
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] aluf;
        logic       mr;
        logic [3:0] st;
        logic [3:0] en;
        logic [1:0] aluc;
        logic [2:0] imm;
        logic [3:0] fl;
    } vec_t;

    vec_t        vecs[$];
    logic [22:0] exp_q[$];
    logic [22:0] care_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [3:0]  cur_cond;
    logic [1:0]  cur_op;
    logic [5:0]  cur_funct;

    task automatic instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f);
        cur_cond  = c;
        cur_op    = o;
        cur_funct = f;
    endtask

    task automatic add(input logic [3:0] aluf, input logic mr, input logic [3:0] st,
                       input logic [3:0] en, input logic [1:0] aluc, input logic [2:0] imm,
                       input logic [3:0] fl);
        vec_t v;
        v.cond = cur_cond; v.op = cur_op; v.funct = cur_funct; v.aluf = aluf; v.mr = mr;
        v.st = st; v.en = en; v.aluc = aluc; v.imm = imm; v.fl = fl;
        vecs.push_back(v);
    endtask

    // Mux settings each state defines: {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}.
    function automatic logic [5:0] mux_val(input logic [3:0] st);
        case (st)
            S_F, S_D: return 6'b0_1_10_10;
            S_MA:     return 6'b0_0_01_00;
            S_MRD:    return 6'b1_0_00_00;
            S_MWB:    return 6'b0_0_00_01;
            S_MWR:    return 6'b1_0_00_00;
            S_EI:     return 6'b0_0_01_00;
            S_BR:     return 6'b0_1_01_10;
            default:  return 6'b0_0_00_00;
        endcase
    endfunction

    function automatic logic [5:0] mux_care(input logic [3:0] st);
        case (st)
            S_F:            return 6'b111111;
            S_D, S_BR:      return 6'b011111;
            S_MA, S_ER, S_EI: return 6'b011100;
            S_MRD, S_MWR:   return 6'b100000;
            S_MWB, S_WB:    return 6'b000011;
            default:        return 6'b000000;
        endcase
    endfunction

    function automatic logic [22:0] care_of(input logic [3:0] st);
        logic [1:0] ac;
        logic [2:0] ic;
        ac = (st == S_F || st == S_MA || st == S_ER || st == S_EI || st == S_WB ||
              st == S_BR) ? 2'b11 : 2'b00;
        ic = (st == S_F) ? 3'b000 : 3'b111;
        return {4'hF, 4'hF, ac, ic, 4'hF, mux_care(st)};
    endfunction

    task automatic check(input string name, input logic [22:0] got, input logic [22:0] want,
                         input logic [22:0] mask);
        n_vec++;
        if (((got ^ want) & mask) != 23'd0) begin
            n_miss++;
            $display("FAIL %s: got %h want %h (care mask %h)", name, got & mask,
                     want & mask, mask);
        end
    endtask

    initial begin
        vec_t        v;
        logic [22:0] e, m;

        rst_n = 1'b0; Cond = 4'hE; Op = 2'b11; Funct = 6'd0; ALUFlags = 4'hF; MemReady = 1'b1;
        #12;
        check("reset_hold", act_w, {S_F, 4'b0000, 15'd0}, {4'hF, 4'hF, 2'b00, 3'b000, 4'hF, 6'd0});
        @(negedge clk);
        MemReady = 1'b0;
        rst_n    = 1'b1;

        // ADD R1,R2,#0xFF: flags untouched despite ALUFlags=1111
        instr(4'hE, 2'b00, 6'b101000);
        add(4'hF, 1, S_F,  4'b1100, 2'b00, 3'b011, 4'h0);
        add(4'hF, 1, S_D,  4'b0000, 2'b00, 3'b011, 4'h0);
        add(4'hF, 1, S_EI, 4'b0000, 2'b00, 3'b011, 4'h0);
        add(4'hF, 1, S_WB, 4'b0010, 2'b00, 3'b011, 4'h0);
        // SUBS reg, Z set at writeback
        instr(4'hE, 2'b00, 6'b000101);
        add(4'hF, 1, S_F,  4'b1100, 2'b00, 3'b011, 4'h0);
        add(4'hF, 1, S_D,  4'b0000, 2'b00, 3'b011, 4'h0);
        add(4'hF, 1, S_ER, 4'b0000, 2'b01, 3'b011, 4'h0);
        add(4'h4, 1, S_WB, 4'b0010, 2'b01, 3'b011, 4'h0);
        // BEQ taken
        instr(4'h0, 2'b10, 6'b000000);
        add(4'hF, 1, S_F,  4'b1100, 2'b00, 3'b010, 4'h4);
        add(4'hF, 1, S_D,  4'b0000, 2'b00, 3'b010, 4'h4);
        add(4'hF, 1, S_BR, 4'b1000, 2'b00, 3'b010, 4'h4);
        // ANDS imm clears flags
        instr(4'hE, 2'b00, 6'b100001);
        add(4'hF, 1, S_F,  4'b1100, 2'b00, 3'b011, 4'h4);
        add(4'hF, 1, S_D,  4'b0000, 2'b00, 3'b011, 4'h4);
        add(4'hF, 1, S_EI, 4'b0000, 2'b10, 3'b011, 4'h4);
        add(4'h0, 1, S_WB, 4'b0010, 2'b10, 3'b011, 4'h4);
        // BEQ not taken
        instr(4'h0, 2'b10, 6'b000000);
        add(4'hF, 1, S_F,  4'b1100, 2'b00, 3'b010, 4'h0);
        add(4'hF, 1, S_D,  4'b0000, 2'b00, 3'b010, 4'h0);
        add(4'hF, 1, S_BR, 4'b0000, 2'b00, 3'b010, 4'h0);
        // LDR with memory stalls in FETCH and MEMRD
        instr(4'hE, 2'b01, 6'b011001);
        add(4'hF, 0, S_F,   4'b0000, 2'b00, 3'b001, 4'h0);
        add(4'hF, 0, S_F,   4'b0000, 2'b00, 3'b001, 4'h0);
        add(4'hF, 1, S_F,   4'b1100, 2'b00, 3'b001, 4'h0);
        add(4'hF, 1, S_D,   4'b0000, 2'b00, 3'b001, 4'h0);
        add(4'hF, 1, S_MA,  4'b0000, 2'b00, 3'b001, 4'h0);
        add(4'hF, 0, S_MRD, 4'b0000, 2'b00, 3'b001, 4'h0);
        add(4'hF, 0, S_MRD, 4'b0000, 2'b00, 3'b001, 4'h0);
        add(4'hF, 0, S_MRD, 4'b0000, 2'b00, 3'b001, 4'h0);
        add(4'hF, 1, S_MRD, 4'b0000, 2'b00, 3'b001, 4'h0);
        add(4'hF, 1, S_MWB, 4'b0010, 2'b00, 3'b001, 4'h0);
        // CMP: no register write, flags load
        instr(4'hE, 2'b00, 6'b010101);
        add(4'hF, 1, S_F,  4'b1100, 2'b00, 3'b011, 4'h0);
        add(4'hF, 1, S_D,  4'b0000, 2'b00, 3'b011, 4'h0);
        add(4'hF, 1, S_ER, 4'b0000, 2'b01, 3'b011, 4'h0);
        add(4'h9, 1, S_WB, 4'b0000, 2'b01, 3'b011, 4'h0);
        // Op=11 NOP
        instr(4'hE, 2'b11, 6'b000000);
        add(4'hF, 1, S_F,  4'b1100, 2'b00, 3'b000, 4'h9);
        add(4'hF, 1, S_D,  4'b0000, 2'b00, 3'b000, 4'h9);
        // STR AL with one stall cycle in MEMWR
        instr(4'hE, 2'b01, 6'b010000);
        add(4'hF, 1, S_F,   4'b1100, 2'b00, 3'b001, 4'h9);
        add(4'hF, 1, S_D,   4'b0000, 2'b00, 3'b001, 4'h9);
        add(4'hF, 1, S_MA,  4'b0000, 2'b00, 3'b001, 4'h9);
        add(4'hF, 0, S_MWR, 4'b0001, 2'b00, 3'b001, 4'h9);
        add(4'hF, 1, S_MWR, 4'b0001, 2'b00, 3'b001, 4'h9);
        // STREQ with Z=0: suppressed
        instr(4'h0, 2'b01, 6'b010000);
        add(4'hF, 1, S_F,   4'b1100, 2'b00, 3'b001, 4'h9);
        add(4'hF, 1, S_D,   4'b0000, 2'b00, 3'b001, 4'h9);
        add(4'hF, 1, S_MA,  4'b0000, 2'b00, 3'b001, 4'h9);
        add(4'hF, 1, S_MWR, 4'b0000, 2'b00, 3'b001, 4'h9);
        // ADDSEQ with Z=0: no write, no flag update
        instr(4'h0, 2'b00, 6'b001001);
        add(4'hF, 1, S_F,  4'b1100, 2'b00, 3'b011, 4'h9);
        add(4'hF, 1, S_D,  4'b0000, 2'b00, 3'b011, 4'h9);
        add(4'hF, 1, S_ER, 4'b0000, 2'b00, 3'b011, 4'h9);
        add(4'h6, 1, S_WB, 4'b0000, 2'b00, 3'b011, 4'h9);
        // ORR with Cond=1111: never executes
        instr(4'hF, 2'b00, 6'b111000);
        add(4'hF, 1, S_F,  4'b1100, 2'b00, 3'b011, 4'h9);
        add(4'hF, 1, S_D,  4'b0000, 2'b00, 3'b011, 4'h9);
        add(4'hF, 1, S_EI, 4'b0000, 2'b11, 3'b011, 4'h9);
        add(4'h0, 1, S_WB, 4'b0000, 2'b11, 3'b011, 4'h9);
        // ORRS AL: N set
        instr(4'hE, 2'b00, 6'b111001);
        add(4'hF, 1, S_F,  4'b1100, 2'b00, 3'b011, 4'h9);
        add(4'hF, 1, S_D,  4'b0000, 2'b00, 3'b011, 4'h9);
        add(4'hF, 1, S_EI, 4'b0000, 2'b11, 3'b011, 4'h9);
        add(4'h8, 1, S_WB, 4'b0010, 2'b11, 3'b011, 4'h9);
        // BLT taken (N!=V), BGE not taken
        instr(4'hB, 2'b10, 6'b000000);
        add(4'hF, 1, S_F,  4'b1100, 2'b00, 3'b010, 4'h8);
        add(4'hF, 1, S_D,  4'b0000, 2'b00, 3'b010, 4'h8);
        add(4'hF, 1, S_BR, 4'b1000, 2'b00, 3'b010, 4'h8);
        instr(4'hA, 2'b10, 6'b000000);
        add(4'hF, 1, S_F,  4'b1100, 2'b00, 3'b010, 4'h8);
        add(4'hF, 1, S_D,  4'b0000, 2'b00, 3'b010, 4'h8);
        add(4'hF, 1, S_BR, 4'b0000, 2'b00, 3'b010, 4'h8);
        // Unsupported cmd with S=1: no write, no flag update
        instr(4'hE, 2'b00, 6'b000011);
        add(4'hF, 1, S_F,  4'b1100, 2'b00, 3'b011, 4'h8);
        add(4'hF, 1, S_D,  4'b0000, 2'b00, 3'b011, 4'h8);
        add(4'hF, 1, S_ER, 4'b0000, 2'b00, 3'b011, 4'h8);
        add(4'h1, 1, S_WB, 4'b0000, 2'b00, 3'b011, 4'h8);
        instr(4'hE, 2'b11, 6'b000000);
        add(4'hF, 0, S_F,  4'b0000, 2'b00, 3'b000, 4'h8);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clk);
            Cond = v.cond; Op = v.op; Funct = v.funct; ALUFlags = v.aluf; MemReady = v.mr;
            exp_q.push_back({v.st, v.en, v.aluc, v.imm, v.fl, mux_val(v.st)});
            care_q.push_back(care_of(v.st));
            #2;
            e = exp_q.pop_front();
            m = care_q.pop_front();
            check($sformatf("vec%0d", i), act_w, e, m);
        end

        // Async reset while MEMWR is stalled with MemWrite asserted
        @(negedge clk);
        Cond = 4'hE; Op = 2'b01; Funct = 6'b010000; ALUFlags = 4'hF; MemReady = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        MemReady = 1'b0;
        #2;
        check("memwr_stall", act_w, {S_MWR, 4'b0001, 15'd0}, {4'hF, 4'hF, 15'd0});
        #1;
        rst_n    = 1'b0;
        MemReady = 1'b1;
        #1;
        check("async_reset", act_w, {S_F, 4'b0000, 15'd0}, {4'hF, 4'hF, 2'b00, 3'b000, 4'hF, 6'd0});
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check("post_reset", act_w, {S_F, 4'b1100, 15'd0}, {4'hF, 4'hF, 15'd0});
        @(posedge clk);
        #2;
        check("post_reset_decode", act_w, {S_D, 4'b0000, 15'd0}, {4'hF, 4'hF, 15'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
